shift_seq_sfr: RTL and testbench

Parametrised multi-mode shift Special Function Register (SFR) that replaces the single-bit left/right shift SFR in the datapath. It supports logical, arithmetic and rotate shifts by a programmable amount, applied STEP bits per clock. A start/busy/done handshake lets the controller FSM issue a shift and wait for completion. The block also exports carry-out and zero status for the flag logic.

---
 rtl/shift_seq_sfr_pkg.sv | 24 ++
 rtl/shift_step.sv | 56 +++++
 rtl/shift_seq_sfr.sv | 116 +++++++++++
 tb/tb_shift_seq_sfr.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_sfr_pkg.sv
// Shared definitions for the multi-mode shift SFR: mode codes, FSM state
// encoding and a constant clog2 helper for deriving field widths.
package shift_seq_sfr_pkg;

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASR = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts i_q by i_s (1..STEP) bits in the
// selected mode and reports the bit that crossed the edge or wrap boundary.
module shift_step
  import shift_seq_sfr_pkg::*;
#(
  parameter int SIZE = 32,
  parameter int SHW  = clog2(SIZE)
) (
  input  logic [SIZE-1:0] i_q,
  input  logic [2:0]      i_mode,
  input  logic [SHW:0]    i_s,
  output logic [SIZE-1:0] o_q,
  output logic            o_carry
);

  // w_inv = SIZE - s; doubles as the rotate back-shift and the top carry index
  logic [SHW:0]   w_inv;
  logic [SHW-1:0] w_hi_idx;
  logic [SHW-1:0] w_lo_idx;

  assign w_inv    = (SHW+1)'(SIZE) - i_s;
  assign w_hi_idx = SHW'(w_inv);
  assign w_lo_idx = SHW'(i_s - (SHW+1)'(1));

  always_comb begin
    o_q     = i_q;
    o_carry = 1'b0;
    case (i_mode)
      MODE_LSL: begin
        o_q     = i_q << i_s;
        o_carry = i_q[w_hi_idx];
      end
      MODE_LSR: begin
        o_q     = i_q >> i_s;
        o_carry = i_q[w_lo_idx];
      end
      MODE_ASR: begin
        o_q     = $signed(i_q) >>> i_s;
        o_carry = i_q[w_lo_idx];
      end
      MODE_ROL: begin
        o_q     = (i_q << i_s) | (i_q >> w_inv);
        o_carry = i_q[w_hi_idx];
      end
      MODE_ROR: begin
        o_q     = (i_q >> i_s) | (i_q << w_inv);
        o_carry = i_q[w_lo_idx];
      end
      default: begin
        o_q     = i_q;
        o_carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_seq_sfr.sv
// Multi-mode shift SFR: shifts Q by a latched amount, up to STEP bits per
// clock, with a start/busy/done handshake, carry-out and zero flags.
// Handshake: start is sampled only in IDLE; busy is high from the accepting
// edge until done retires; done is a one-cycle pulse; ld overrides all.
module shift_seq_sfr
  import shift_seq_sfr_pkg::*;
#(
  parameter  int SIZE = 32,
  parameter  int STEP = 1,
  localparam int SHW  = clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic [SIZE-1:0] D,
  input  logic            start,
  input  logic [2:0]      mode,
  input  logic [SHW-1:0]  amt,
  output logic [SIZE-1:0] Q,
  output logic            busy,
  output logic            done,
  output logic            carry,
  output logic            zero,
  output state_t          o_dbg_state
);

  state_t          r_state;
  logic [SIZE-1:0] r_q;
  logic [SHW-1:0]  r_cnt;
  logic [2:0]      r_mode;
  logic            r_carry;
  logic            r_busy;
  logic            r_done;

  logic [SHW:0]    w_cnt_ext;
  logic [SHW:0]    w_s;
  logic            w_last;
  logic [SIZE-1:0] w_q_next;
  logic            w_carry_next;

  // Step size is min(STEP, remaining); the final step may be partial
  assign w_cnt_ext = {1'b0, r_cnt};
  assign w_s       = (w_cnt_ext < (SHW+1)'(STEP)) ? w_cnt_ext : (SHW+1)'(STEP);
  assign w_last    = (w_cnt_ext <= (SHW+1)'(STEP));

  shift_step #(.SIZE(SIZE), .SHW(SHW)) u_step (
    .i_q    (r_q),
    .i_mode (r_mode),
    .i_s    (w_s),
    .o_q    (w_q_next),
    .o_carry(w_carry_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_LSL;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (ld) begin
      r_state <= ST_IDLE;
      r_q     <= D;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mode  <= mode;
            r_cnt   <= amt;
            r_carry <= 1'b0;
            r_busy  <= 1'b1;
            if ((amt != '0) && (mode <= MODE_ROR)) begin
              r_state <= ST_SHIFT;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_q     <= w_q_next;
          r_carry <= w_carry_next;
          r_cnt   <= SHW'(w_cnt_ext - w_s);
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign Q           = r_q;
  assign busy        = r_busy;
  assign done        = r_done;
  assign carry       = r_carry;
  assign zero        = ~|r_q;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_seq_sfr.sv
// Directed bench for shift_seq_sfr: an 8-bit STEP=1 instance (a_*) and a
// 32-bit STEP=4 instance (b_*) driven from one clock.
module tb_shift_seq_sfr;
  import shift_seq_sfr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       a_ld, a_start, a_busy, a_done, a_carry, a_zero;
  logic [7:0] a_d, a_q;
  logic [2:0] a_mode, a_amt;
  state_t     a_state;

  logic        b_ld, b_start, b_busy, b_done, b_carry, b_zero;
  logic [31:0] b_d, b_q;
  logic [2:0]  b_mode;
  logic [4:0]  b_amt;
  state_t      b_state;

  shift_seq_sfr #(.SIZE(8), .STEP(1)) dut_a (
    .clk(clk), .rst(rst), .ld(a_ld), .D(a_d), .start(a_start), .mode(a_mode),
    .amt(a_amt), .Q(a_q), .busy(a_busy), .done(a_done), .carry(a_carry),
    .zero(a_zero), .o_dbg_state(a_state)
  );

  shift_seq_sfr #(.SIZE(32), .STEP(4)) dut_b (
    .clk(clk), .rst(rst), .ld(b_ld), .D(b_d), .start(b_start), .mode(b_mode),
    .amt(b_amt), .Q(b_q), .busy(b_busy), .done(b_done), .carry(b_carry),
    .zero(b_zero), .o_dbg_state(b_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_load(input logic [7:0] d);
    a_ld = 1'b1; a_d = d;
    tick();
    a_ld = 1'b0;
  endtask

  // Pulses start for one edge (edge k), then scrambles mode/amt
  task automatic a_go(input logic [2:0] m, input logic [2:0] n);
    a_start = 1'b1; a_mode = m; a_amt = n;
    tick();
    a_start = 1'b0; a_mode = 3'd7; a_amt = 3'd7;
  endtask

  // Observes j = 0.. samples after edge k+j; bounded at 12 cycles
  task automatic a_run(output int busy_cnt, output int done_cnt, output int done_at);
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int j = 0; j < 12; j++) begin
      if (a_busy) busy_cnt++;
      if (a_done) begin done_cnt++; done_at = j; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_ld = 0; a_start = 0; a_d = 0; a_mode = 0; a_amt = 0;
    b_ld = 0; b_start = 0; b_d = 0; b_mode = 0; b_amt = 0;
    tick(); tick();
    n_checks++; if (a_q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h expected 00", a_q); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", a_done); end
    n_checks++; if (a_carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b expected 0", a_carry); end
    n_checks++; if (a_zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b expected 1", a_zero); end
    n_checks++; if (a_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", a_state); end
    n_checks++; if (b_q !== 32'h0) begin n_fail++; $display("FAIL reset_b_q: got %h expected 0", b_q); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lsl();
    int bc, dc, da;
    a_load(8'h96);
    a_go(MODE_LSL, 3'd3);
    a_run(bc, dc, da);
    n_checks++; if (bc != 4) begin n_fail++; $display("FAIL lsl_busy_cycles: got %0d expected 4", bc); end
    n_checks++; if (dc != 1) begin n_fail++; $display("FAIL lsl_done_count: got %0d expected 1", dc); end
    n_checks++; if (da != 3) begin n_fail++; $display("FAIL lsl_done_at: got %0d expected 3", da); end
    n_checks++; if (a_q !== 8'hB0) begin n_fail++; $display("FAIL lsl_q: got %h expected b0", a_q); end
    n_checks++; if (a_carry !== 1'b0) begin n_fail++; $display("FAIL lsl_carry: got %b expected 0", a_carry); end
  endtask

  task automatic test_asr();
    int bc, dc, da;
    a_load(8'h96);
    a_go(MODE_ASR, 3'd2);
    a_run(bc, dc, da);
    n_checks++; if (da != 2) begin n_fail++; $display("FAIL asr_done_at: got %0d expected 2", da); end
    n_checks++; if (a_q !== 8'hE5) begin n_fail++; $display("FAIL asr_q: got %h expected e5", a_q); end
    n_checks++; if (a_carry !== 1'b1) begin n_fail++; $display("FAIL asr_carry: got %b expected 1", a_carry); end
  endtask

  task automatic test_ror();
    int bc, dc, da;
    a_load(8'h96);
    a_go(MODE_ROR, 3'd3);
    a_run(bc, dc, da);
    n_checks++; if (a_q !== 8'hD2) begin n_fail++; $display("FAIL ror_q: got %h expected d2", a_q); end
    n_checks++; if (a_carry !== 1'b1) begin n_fail++; $display("FAIL ror_carry: got %b expected 1", a_carry); end
  endtask

  task automatic test_rol_then_reserved();
    int bc, dc, da;
    a_load(8'h96);
    a_go(MODE_ROL, 3'd1);
    a_run(bc, dc, da);
    n_checks++; if (a_q !== 8'h2D) begin n_fail++; $display("FAIL rol_q: got %h expected 2d", a_q); end
    n_checks++; if (a_carry !== 1'b1) begin n_fail++; $display("FAIL rol_carry: got %b expected 1", a_carry); end
    a_go(3'd5, 3'd3);
    a_run(bc, dc, da);
    n_checks++; if (a_q !== 8'h2D) begin n_fail++; $display("FAIL rsv_q: got %h expected 2d", a_q); end
    n_checks++; if (a_carry !== 1'b0) begin n_fail++; $display("FAIL rsv_carry: got %b expected 0", a_carry); end
    n_checks++; if (da != 0 || bc != 1) begin n_fail++; $display("FAIL rsv_timing: got done_at=%0d busy=%0d expected 0 and 1", da, bc); end
  endtask

  task automatic test_lsr_step4();
    int bc, dc, da;
    b_ld = 1'b1; b_d = 32'h0000_00F1;
    tick();
    b_ld = 1'b0;
    b_start = 1'b1; b_mode = MODE_LSR; b_amt = 5'd6;
    tick();
    b_start = 1'b0; b_mode = 3'd0; b_amt = 5'd31;
    bc = 0; dc = 0; da = -1;
    for (int j = 0; j < 12; j++) begin
      if (b_busy) bc++;
      if (b_done) begin dc++; da = j; end
      tick();
    end
    n_checks++; if (da != 2) begin n_fail++; $display("FAIL lsr4_done_at: got %0d expected 2", da); end
    n_checks++; if (bc != 3) begin n_fail++; $display("FAIL lsr4_busy_cycles: got %0d expected 3", bc); end
    n_checks++; if (b_q !== 32'h0000_0003) begin n_fail++; $display("FAIL lsr4_q: got %h expected 00000003", b_q); end
    n_checks++; if (b_carry !== 1'b1) begin n_fail++; $display("FAIL lsr4_carry: got %b expected 1", b_carry); end
  endtask

  task automatic test_amt_zero_and_ignored_start();
    int bc, dc, da;
    a_load(8'h5A);
    a_go(MODE_LSL, 3'd0);
    a_run(bc, dc, da);
    n_checks++; if (da != 0 || dc != 1) begin n_fail++; $display("FAIL amt0_done: got at=%0d count=%0d expected 0 and 1", da, dc); end
    n_checks++; if (a_q !== 8'h5A) begin n_fail++; $display("FAIL amt0_q: got %h expected 5a", a_q); end
    n_checks++; if (a_carry !== 1'b0) begin n_fail++; $display("FAIL amt0_carry: got %b expected 0", a_carry); end
    // A second start mid-shift with a different mode/amt must change nothing
    a_go(MODE_LSL, 3'd3);
    dc = 0; da = -1;
    for (int j = 0; j < 12; j++) begin
      if (a_done) begin dc++; da = j; end
      a_start = (j == 1); a_mode = MODE_ROR; a_amt = 3'd0;
      tick();
    end
    a_start = 1'b0;
    n_checks++; if (dc != 1 || da != 3) begin n_fail++; $display("FAIL busy_start: got count=%0d at=%0d expected 1 and 3", dc, da); end
    n_checks++; if (a_q !== 8'hD0) begin n_fail++; $display("FAIL busy_start_q: got %h expected d0", a_q); end
  endtask

  task automatic test_ld_priority_and_abort();
    int dc;
    a_ld = 1'b1; a_d = 8'h96; a_start = 1'b1; a_mode = MODE_LSL; a_amt = 3'd2;
    tick();
    a_ld = 1'b0; a_start = 1'b0;
    tick(); tick();
    n_checks++; if (a_busy !== 1'b0 || a_q !== 8'h96) begin n_fail++; $display("FAIL ld_wins: got busy=%b q=%h expected 0 and 96", a_busy, a_q); end
    a_go(MODE_LSL, 3'd5);
    tick();
    a_ld = 1'b1; a_d = 8'h00;
    tick();
    a_ld = 1'b0;
    n_checks++; if (a_q !== 8'h00 || a_zero !== 1'b1) begin n_fail++; $display("FAIL abort_q: got q=%h zero=%b expected 00 and 1", a_q, a_zero); end
    n_checks++; if (a_state !== ST_IDLE || a_busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got state=%0d busy=%b expected 0 and 0", a_state, a_busy); end
    dc = 0;
    for (int j = 0; j < 8; j++) begin
      if (a_done) dc++;
      tick();
    end
    n_checks++; if (dc != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", dc); end
  endtask

  task automatic test_async_reset();
    a_load(8'hFF);
    a_go(MODE_ROL, 3'd4);
    tick();
    n_checks++; if (a_busy !== 1'b1 || a_carry !== 1'b1) begin n_fail++; $display("FAIL pre_rst: got busy=%b carry=%b expected 1 and 1", a_busy, a_carry); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (a_q !== 8'h00 || a_zero !== 1'b1) begin n_fail++; $display("FAIL async_rst_q: got q=%h zero=%b expected 00 and 1", a_q, a_zero); end
    n_checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_carry !== 1'b0) begin n_fail++; $display("FAIL async_rst_flags: got busy=%b done=%b carry=%b expected 0 0 0", a_busy, a_done, a_carry); end
    n_checks++; if (a_state !== ST_IDLE) begin n_fail++; $display("FAIL async_rst_state: got %0d expected 0", a_state); end
    #1 rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lsl();
    test_asr();
    test_ror();
    test_rol_then_reserved();
    test_lsr_step4();
    test_amt_zero_and_ignored_start();
    test_ld_priority_and_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
